// File: rtl/cam_top.sv
// Two-image content-addressable memory: writes by address, parallel search with registered hit flags.
// Optional macro CAM_MATCH_ADDR_EN adds registered lowest-matching-address outputs per image.
module cam_top #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        we,
  input  logic              match_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
`ifdef CAM_MATCH_ADDR_EN
  output logic [ADDR_W-1:0] match_addr0,
  output logic [ADDR_W-1:0] match_addr1,
`endif
  output logic [1:0]        match
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]         data_q [2][DEPTH];
  // Contents deliberately survive reset; valid bits only start cleared at power-up.
  logic [1:0][DEPTH-1:0]     valid_q = '0;

  logic                      addr_ok;
  logic [IdxW-1:0]           idx;
  logic [1:0][DEPTH-1:0]     hit_vec;
  logic [1:0]                hit;
  logic [1:0]                match_d, match_q;

  assign addr_ok = (32'(addr) < DEPTH);
  assign idx     = addr[IdxW-1:0];

  // Storage: out-of-range addresses are dropped, never wrapped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i] && addr_ok) begin
        data_q[i][idx]  <= din;
        valid_q[i][idx] <= 1'b1;
      end
    end
  end

  // Search sees pre-write contents, so a same-cycle write is not yet visible.
  always_comb begin
    hit_vec = '0;
    hit     = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        hit_vec[i][k] = valid_q[i][k] && (data_q[i][k] == din);
      end
      hit[i] = |hit_vec[i];
    end
  end

  always_comb begin
    match_d = '0;
    if (match_en) begin
      match_d = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      match_q <= '0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;

`ifdef CAM_MATCH_ADDR_EN
  logic [ADDR_W-1:0] first0_d, first1_d;
  logic [ADDR_W-1:0] first0_q, first1_q;

  // Scan downward so the lowest matching address is the last one assigned.
  always_comb begin
    first0_d = '0;
    first1_d = '0;
    if (match_en) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (hit_vec[0][k]) begin
          first0_d = ADDR_W'(k);
        end
        if (hit_vec[1][k]) begin
          first1_d = ADDR_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      first0_q <= '0;
      first1_q <= '0;
    end else begin
      first0_q <= first0_d;
      first1_q <= first1_d;
    end
  end

  assign match_addr0 = first0_q;
  assign match_addr1 = first1_q;
`endif

endmodule

// File: tb/tb_cam_top.sv
// Randomised and directed bench for cam_top against an associative-array membership model.
module tb_cam_top;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        we;
  logic              match_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [1:0]        match;
`ifdef CAM_MATCH_ADDR_EN
  logic [ADDR_W-1:0] match_addr0;
  logic [ADDR_W-1:0] match_addr1;
`endif

  int checks   = 0;
  int failures = 0;

  // Key = image*1000 + address; presence of a key means the entry is valid.
  logic [DATA_W-1:0] model [int];

  cam_top #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .match_en   (match_en),
    .addr       (addr),
    .din        (din),
`ifdef CAM_MATCH_ADDR_EN
    .match_addr0(match_addr0),
    .match_addr1(match_addr1),
`endif
    .match      (match)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hit(input int img, input logic [DATA_W-1:0] key,
                                     output int first);
    logic found;
    found = 1'b0;
    first = 0;
    foreach (model[k]) begin
      if (!found && (k / 1000 == img) && model[k] == key) begin
        found = 1'b1;
        first = k % 1000;
      end
    end
    return found;
  endfunction

  // One clock: drive at negedge, sample at the following negedge. want < 0 skips the fixed check.
  task automatic step(input logic rst_n, input logic [1:0] w, input logic me, input int a,
                      input logic [DATA_W-1:0] d, input string tag, input int want);
    logic [1:0] exp_m;
    logic       h0, h1;
    int         f0, f1;
    reset    = rst_n;
    we       = w;
    match_en = me;
    addr     = ADDR_W'(a);
    din      = d;
    h0 = model_hit(0, d, f0);
    h1 = model_hit(1, d, f1);
    exp_m = (rst_n && me) ? {h1, h0} : 2'b00;
    if (!(rst_n && me && h0)) f0 = 0;
    if (!(rst_n && me && h1)) f1 = 0;
    for (int i = 0; i < 2; i++) begin
      if (w[i] && a < int'(DEPTH)) model[i * 1000 + a] = d;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_model"}, 32'(match), 32'(exp_m));
    if (want >= 0) check_eq({tag, "_plan"}, 32'(match), want);
`ifdef CAM_MATCH_ADDR_EN
    check_eq({tag, "_addr0"}, 32'(match_addr0), f0);
    check_eq({tag, "_addr1"}, 32'(match_addr1), f1);
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] img0_w [5];
    logic [DATA_W-1:0] img1_w [5];
    logic [DATA_W-1:0] pool [8];
    img0_w = '{24'hFFEE11, 24'h123456, 24'hA12789, 24'h987654, 24'h156789};
    img1_w = '{24'h123589, 24'h123457, 24'h12AD56, 24'h948563, 24'h12ABCD};
    pool   = '{24'h000000, 24'hFFEE11, 24'h123456, 24'h12ABCD,
               24'hABCDEF, 24'h555555, 24'h777777, 24'h0F0F0F};
    reset = 1'b0; we = '0; match_en = 1'b0; addr = '0; din = '0;
    @(negedge clk);

    step(1'b0, 2'b00, 1'b1, 0, 24'h000000, "reset_state", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'h000000, "empty_zero", 0);

    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0, i + 1, img0_w[i], "wr_img0", 0);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 1'b1, 0, img0_w[i], "srch_img0", 1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 1'b0, i + 1, img1_w[i], "wr_img1", 0);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 1'b1, 0, img1_w[i], "srch_img1", 2);
    step(1'b1, 2'b00, 1'b1, 0, 24'h123456, "srch_123456", 1);
    step(1'b1, 2'b00, 1'b1, 0, 24'h000000, "srch_zero", 0);

    step(1'b0, 2'b00, 1'b1, 0, 24'hFFEE11, "rst_mid", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'h12ABCD, "post_rst_img1", 2);
    step(1'b1, 2'b00, 1'b1, 0, 24'hFFEE11, "post_rst_img0", 1);

    step(1'b1, 2'b11, 1'b0, 7, 24'hABCDEF, "wr_both", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'hABCDEF, "srch_both", 3);
    step(1'b1, 2'b01, 1'b0, 40, 24'h555555, "wr_oor", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'h555555, "srch_oor", 0);
    step(1'b1, 2'b01, 1'b0, 31, 24'h0F0F0F, "wr_top", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'h0F0F0F, "srch_top", 1);

    step(1'b1, 2'b01, 1'b1, 9, 24'h777777, "wr_srch_same", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'h777777, "srch_next", 1);
    step(1'b1, 2'b01, 1'b0, 12, 24'hFFEE11, "wr_dup", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'hFFEE11, "srch_dup", 1);
    step(1'b1, 2'b00, 1'b0, 0, 24'hFFEE11, "match_en_off", 0);
    step(1'b1, 2'b01, 1'b0, 1, 24'h246802, "overwrite", 0);
    step(1'b1, 2'b00, 1'b1, 0, 24'h246802, "srch_new", 1);

    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic [1:0] w;
      r = ($urandom_range(0, 19) != 0);
      w = r ? 2'($urandom_range(0, 3)) : 2'b00;
      step(r, w, 1'($urandom_range(0, 1)), $urandom_range(0, 47),
           pool[$urandom_range(0, 7)], "rand", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
